// File: rtl/lead_count_unit_pkg.sv
// Shared constants for the leading-zero/one count unit: opcode encodings and FSM states.
package lead_count_unit_pkg;

    localparam logic OP_CLZ = 1'b0;
    localparam logic OP_CLO = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/lead_count_step.sv
// One binary-search step: if the top w bits of x are all zero, count them and shift them out.
module lead_count_step #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] w,
    output logic [WIDTH-1:0] x_next,
    output logic [CNT_W-1:0] cnt_next
);

    logic [WIDTH-1:0] top_mask;
    logic             top_zero;

    // The mask selects the upper w bits; a masked compare avoids a variable-width part select.
    always_comb begin
        top_mask = ~({WIDTH{1'b1}} >> w);
        top_zero = ((x & top_mask) == {WIDTH{1'b0}});
        if (top_zero) begin
            x_next   = x << w;
            cnt_next = cnt + w;
        end else begin
            x_next   = x;
            cnt_next = cnt;
        end
    end

endmodule

// File: rtl/lead_count_unit.sv
// Multi-cycle CLZ/CLO unit: log2(WIDTH)-step binary search with a start/busy/done handshake.
module lead_count_unit
    import lead_count_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int STEPS = $clog2(WIDTH),
    localparam int CNT_W = STEPS + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result
);

    localparam logic [CNT_W-1:0] W_INIT = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(1);

    state_t           state_r;
    state_t           state_nx;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] x_nx;
    logic [WIDTH-1:0] step_x;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] w_r;
    logic [CNT_W-1:0] w_nx;
    logic [CNT_W-1:0] result_r;
    logic [CNT_W-1:0] result_nx;
    logic [WIDTH-1:0] load_x;

    lead_count_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .x        (x_r),
        .cnt      (cnt_r),
        .w        (w_r),
        .x_next   (step_x),
        .cnt_next (step_cnt)
    );

    // CLO is computed as CLZ of the inverted operand.
    always_comb begin
        case (op)
            OP_CLZ:  load_x = A;
            OP_CLO:  load_x = ~A;
            default: load_x = A;
        endcase
    end

    // Next-state and datapath updates; every register holds unless its state says otherwise.
    always_comb begin
        state_nx  = state_r;
        x_nx      = x_r;
        cnt_nx    = cnt_r;
        w_nx      = w_r;
        result_nx = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    x_nx     = load_x;
                    cnt_nx   = {CNT_W{1'b0}};
                    w_nx     = W_INIT;
                    state_nx = ST_SEARCH;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                x_nx   = step_x;
                cnt_nx = step_cnt;
                w_nx   = w_r >> 1;
                if (w_r == W_LAST) begin
                    // After the last shift only the MSB is untested; it supplies the final +1.
                    result_nx = step_cnt + {{(CNT_W-1){1'b0}}, ~step_x[WIDTH-1]};
                    state_nx  = ST_DONE;
                end else begin
                    state_nx = ST_SEARCH;
                end
            end
            ST_DONE: begin
                if (start) begin
                    x_nx     = load_x;
                    cnt_nx   = {CNT_W{1'b0}};
                    w_nx     = W_INIT;
                    state_nx = ST_SEARCH;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            x_r      <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            w_r      <= {CNT_W{1'b0}};
            result_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nx;
            x_r      <= x_nx;
            cnt_r    <= cnt_nx;
            w_r      <= w_nx;
            result_r <= result_nx;
        end
    end

    assign busy   = (state_r == ST_SEARCH);
    assign done   = (state_r == ST_DONE);
    assign result = result_r;

endmodule

// File: tb/tb_lead_count_unit.sv
// Self-checking bench for lead_count_unit: directed table, back-to-back, mid-search reset, random sweep.
module tb_lead_count_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic        busy;
    logic        done;
    logic [5:0]  result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lead_count_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        int          exp;
    } vec_t;

    vec_t vecs[7];

    // Reference: walk down from the MSB while bits equal the counted value.
    function automatic int ref_count(logic o, logic [31:0] a);
        int c = 0;
        for (int i = 31; i >= 0; i--) begin
            if (a[i] !== o) break;
            c++;
        end
        return c;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input int exp,
                          input string name, input bit noisy);
        int n;
        int bcyc;
        @(negedge clk);
        start = 1'b1; op = o; A = a;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        bcyc = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) bcyc++;
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                op    = 1'($urandom_range(0, 1));
                A     = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, " latency"}, n + 1, 6);
        check({name, " busy cycles"}, bcyc, 5);
        check({name, " result"}, int'(result), exp);
        @(negedge clk);
        check({name, " done single pulse"}, int'(done), 0);
        check({name, " result hold"}, int'(result), exp);
    endtask

    initial begin
        int n;
        int seen;
        logic        o;
        logic [31:0] r;
        logic [31:0] v;
        int          k;

        vecs[0] = '{1'b0, 32'h0001_0000, 15};
        vecs[1] = '{1'b0, 32'h0000_0000, 32};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32};
        vecs[3] = '{1'b0, 32'h8000_0000, 0};
        vecs[4] = '{1'b1, 32'hF000_0000, 4};
        vecs[5] = '{1'b1, 32'h7FFF_FFFF, 0};
        vecs[6] = '{1'b0, 32'h0000_0001, 31};

        reset = 1'b0; start = 1'b0; op = 1'b0; A = 32'h0;
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset result", int'(result), 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
        end

        // Back-to-back: start held high, operand swapped only at each done.
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 32'h0000_0001;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            @(negedge clk);
            n = 1;
            while (done !== 1'b1 && n < 20) begin
                A  = $urandom;
                op = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            check($sformatf("b2b%0d spacing", j), n, 6);
            check($sformatf("b2b%0d result", j), int'(result), (j % 2 == 0) ? 31 : 4);
            op = 1'b0;
            A  = (j % 2 == 0) ? 32'h0F00_0000 : 32'h0000_0001;
            if (j == 4) start = 1'b0;
        end
        @(negedge clk);
        check("b2b idle after stop", int'(busy), 0);

        // Reset in the third search cycle aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; op = 1'b0; A = 32'h0000_00FF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort result", int'(result), 0);
        reset = 1'b1;
        seen = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort no done", seen, 0);
        run_op(1'b0, 32'h0000_00FF, 24, "fresh after reset", 1'b0);

        for (int i = 0; i < 3000; i++) begin
            o = 1'($urandom_range(0, 1));
            r = $urandom;
            k = $urandom_range(0, 32);
            v = (k == 32) ? 32'h0 : (r >> k);
            if ($urandom_range(0, 3) == 0) v = r;
            v = o ? ~v : v;
            run_op(o, v, ref_count(o, v), $sformatf("rand%0d", i), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
